// File: rtl/led_frame_ring_pkg.sv
// led_cube_pkg: shared controller mode encoding and width helpers for the LED frame ring.
package led_cube_pkg;

    typedef enum logic [3:0] {
        MODE_OFF     = 4'h0,
        MODE_DISPLAY = 4'h1,
        MODE_TEST    = 4'h2,
        STREAM_MODE  = 4'h3
    } mode_t;

    // Width of a counter that must hold every value 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/led_frame_ring_if.sv
// led_frame_ring_if: stream input and display-side signals of the LED frame ring.
interface led_frame_ring_if
    import led_cube_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int FRAME_BYTES = 64,
    parameter int NUM_FRAMES  = 8
);
    localparam int AW = $clog2(FRAME_BYTES);
    localparam int CW = cnt_w(NUM_FRAMES);

    logic [3:0]        mode;
    logic              new_data;
    logic [DATA_W-1:0] data_in;
    logic [AW-1:0]     frame_addr;
    logic              frame_done;
    logic [DATA_W-1:0] data_to_latch;
    logic              frame_valid;
    logic              buf_full;
    logic [CW-1:0]     frames_stored;
    logic              overflow;

    modport master (
        output mode, new_data, data_in, frame_addr, frame_done,
        input  data_to_latch, frame_valid, buf_full, frames_stored, overflow
    );

    modport slave (
        input  mode, new_data, data_in, frame_addr, frame_done,
        output data_to_latch, frame_valid, buf_full, frames_stored, overflow
    );

endinterface

// File: rtl/led_frame_ram.sv
// led_frame_ram: simple dual-port frame store, synchronous read with a clearable output register.
module led_frame_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 512
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    input  logic                     clr_i,
    output logic [DATA_W-1:0]        rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Only the output register is reset; the array keeps whatever it holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= clr_i ? '0 : mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/led_frame_ring.sv
// led_frame_ring: ring of NUM_FRAMES frame slots fed by a byte stream, read in order by the display.
// Define LED_RING_BLANK_EN to force data_to_latch to 0 while no frame is stored.
module led_frame_ring
    import led_cube_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int FRAME_BYTES = 64,
    parameter int NUM_FRAMES  = 8
) (
    input logic              clk,
    input logic              rst_n,
    led_frame_ring_if.slave  bus
);
    localparam int AW = $clog2(FRAME_BYTES);
    localparam int SW = $clog2(NUM_FRAMES);
    localparam int CW = cnt_w(NUM_FRAMES);

    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [SW-1:0] wr_slot_q, wr_slot_d;
    logic [SW-1:0] rd_slot_q, rd_slot_d;
    logic [CW-1:0] count_q, count_d;
    logic          drop_q, drop_d;
    logic          ovf_q, ovf_d;
    logic          stream, accept, first, last, full, drop_now, commit, adv, clr;
    logic [CW:0]   sum;

    always_comb begin
        stream    = bus.mode == STREAM_MODE;
        accept    = bus.new_data && stream;
        first     = accept && wr_addr_q == '0;
        last      = accept && wr_addr_q == AW'(FRAME_BYTES - 1);
        full      = count_q == CW'(NUM_FRAMES);
        // A frame starting while full is suppressed from its very first word.
        drop_now  = first ? full : drop_q;
        commit    = last && !drop_now;
        sum       = {1'b0, count_q} + (CW + 1)'(commit);
        adv       = bus.frame_done && sum >= (CW + 1)'(2);
        wr_addr_d = stream ? wr_addr_q + AW'(accept) : '0;
        wr_slot_d = stream ? wr_slot_q + SW'(commit) : '0;
        rd_slot_d = stream ? rd_slot_q + SW'(adv) : '0;
        count_d   = stream ? CW'(sum - (CW + 1)'(adv)) : '0;
        drop_d    = stream && (last ? 1'b0 : (first ? full : drop_q));
        ovf_d     = stream && (ovf_q || (last && drop_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_q <= '0;
            wr_slot_q <= '0;
            rd_slot_q <= '0;
            count_q   <= '0;
            drop_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            wr_addr_q <= wr_addr_d;
            wr_slot_q <= wr_slot_d;
            rd_slot_q <= rd_slot_d;
            count_q   <= count_d;
            drop_q    <= drop_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef LED_RING_BLANK_EN
    assign clr = count_q == '0;
`else
    assign clr = 1'b0;
`endif

    led_frame_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (NUM_FRAMES * FRAME_BYTES)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (accept && !drop_now),
        .waddr_i ({wr_slot_q, wr_addr_q}),
        .wdata_i (bus.data_in),
        .raddr_i ({rd_slot_q, bus.frame_addr}),
        .clr_i   (clr),
        .rdata_o (bus.data_to_latch)
    );

    assign bus.frame_valid   = count_q != '0;
    assign bus.buf_full      = full;
    assign bus.frames_stored = count_q;
    assign bus.overflow      = ovf_q;

endmodule

// File: doc/led_frame_ring.md
# led_frame_ring

Parametrised multi-frame stream buffer for the LED cube controller. Accepts a byte stream of frame data while the controller is in stream mode, and stores complete frames in a ring of NUM_FRAMES slots. Presents the oldest committed frame to the latch driver, indexed by frame_addr. The display side consumes frames in order on a frame_done pulse, and repeats the last frame when no newer frame is available.

## Interface
- DATA_W, 8: bits per stored byte/column word.
- FRAME_BYTES, 64: words per frame; power of two, ≥2.
- NUM_FRAMES, 8: ring slots; power of two, ≥2.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  4  controller mode; streaming is active only when mode == STREAM_MODE.
- new_data  in  1  single-cycle strobe: data_in is valid this cycle.
- data_in  in  DATA_W  stream word.
- frame_addr  in  $clog2(FRAME_BYTES)  word index within the displayed frame.
- frame_done  in  1  single-cycle pulse from the display: the current frame has been shown.
- data_to_latch  out  DATA_W  word at frame_addr of the read frame, registered.
- frame_valid  out  1  at least one committed frame is stored.
- buf_full  out  1  frames_stored == NUM_FRAMES.
- frames_stored  out  $clog2(NUM_FRAMES+1)  committed frames held, including the frame being displayed.
- overflow  out  1  sticky: at least one frame was discarded.

## Operation
- Internal state:
  - wr_addr (word index), wr_slot and rd_slot (ring indices, wrap modulo NUM_FRAMES), count (drives frames_stored), drop (frame currently being discarded).
- Accepted word: new_data && mode == STREAM_MODE.
- Write path:
  - If !drop, mem[wr_slot][wr_addr] <= data_in.
  - wr_addr increments on every accepted word, including dropped ones, so frame alignment is preserved.
- Frame start (accepted word with wr_addr == 0):
  - drop <= buf_full. A frame whose first word arrives while full is discarded in its entirety.
  - That frame's first word is already suppressed when buf_full is high.
- Frame end (accepted word with wr_addr == FRAME_BYTES-1):
  - wr_addr wraps to 0.
  - If not dropping, commit: wr_slot++ and count++.
  - If dropping, overflow <= 1 and drop <= 0.
- Read advance on frame_done:
  - Advance when (count + commit_this_cycle) ≥ 2: rd_slot++ and count--.
  - Otherwise hold, so the last frame repeats.
  - frame_done with count == 0 is ignored.
- Commit and advance in the same cycle: count is unchanged; both slot pointers move.
- Full cannot arise mid-frame because count only rises on commit. Once a drop has started, it continues to frame end even if a slot frees.
- Mode exit: any cycle with mode != STREAM_MODE synchronously clears wr_addr, wr_slot, rd_slot, count, drop and overflow. Memory contents are retained.
- frame_valid = count != 0; buf_full = count == NUM_FRAMES.

## Timing
- Reset (asynchronous): pointers, count, drop and overflow cleared to 0; data_to_latch = 0. Memory is not reset.
- Write-to-visible: a frame committed at edge t can be read from the cycle after t if it is the oldest frame.
- Read latency: 1 cycle. data_to_latch at edge t+1 reflects frame_addr and rd_slot as sampled at edge t.
- After an advancing frame_done at edge t, frame_addr sampled at edge t+1 returns new-frame data at edge t+2.
- Status outputs (frame_valid, buf_full, frames_stored, overflow) are registered and update at the same edge as the event that changes them.
- Reset asserted mid-frame: the partial frame is lost and the next accepted word is word 0 of slot 0.

## Configuration
- LED_RING_BLANK_EN defined: data_to_latch is forced to 0 whenever count == 0 (registered, same 1-cycle latency).
- LED_RING_BLANK_EN undefined: data_to_latch always reflects mem[rd_slot][frame_addr], including stale contents.

## Structure
- led_cube_pkg holds:
  - the mode_t enum and STREAM_MODE (4'h3);
  - a width helper function for count.
- Sub-module led_frame_ram: a simple dual-port memory, NUM_FRAMES*FRAME_BYTES deep by DATA_W wide, with synchronous read.
  - Write address is {wr_slot, wr_addr}; read address is {rd_slot, frame_addr}.

## Test plan
- Stream 64 words 0x00..0x3F, then sweep frame_addr 0..63 → data_to_latch = frame_addr one cycle later; frame_valid = 1; frames_stored = 1.
- Stream 3 frames (fill 0xA1, 0xA2, 0xA3), then pulse frame_done 3 times → output 0xA1, 0xA2, 0xA3, 0xA3 (repeat); frames_stored 3→2→1→1.
- Stream 9 frames with no frame_done → buf_full after frame 8; frame 9 discarded; overflow = 1. frame_done then frees a slot, and frame 10 is stored correctly aligned.
- frame_done on the same cycle as the last word of frame 2 (count == 1) → rd_slot advances; frames_stored stays 1; output shows frame 2.
- After 32 words, switch mode to 4'h0 for one cycle, then back → count = 0, overflow = 0; the next 64 words form frame 0.
- Assert rst_n low asynchronously mid-frame → all outputs 0 immediately. With LED_RING_BLANK_EN, data_to_latch stays 0 until the first commit.
